dmem_arbiter: RTL and testbench

- Two-requester round-robin arbiter that time-shares the single-port 1024x32 data memory.
- Requester 0 is the CPU load/store path. Requester 1 is a debug/program loader.
- Each requester drives a held request (addr, write enable, write data). The arbiter serialises the requests onto the memory's write-enable/address/data-in port, captures the read data, and returns a one-cycle acknowledge.
- The block sits between the requesters and the data memory. It drives the memory's regWrEn, addr and dataIn inputs and reads its combinational dataOut.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/rr_pick2.sv | 21 ++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int DATA_W_DEFAULT = 32;

  // Requester ids as carried in the latched grant
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin selector
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  // A lone request wins outright; on contention the requester not granted last time wins
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the single-port data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_regWrEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic              latch_en;
  logic              capture_en;
  logic              pick_valid;
  logic              pick_winner;
  logic              last_grant;
  logic              cur_id;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Next-state: sample in IDLE, one memory cycle in SERVE, acknowledge in DONE
  always_comb begin
    state_nxt  = state;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = SERVE;
          latch_en  = 1'b1;
        end
      end
      SERVE: begin
        state_nxt  = DONE;
        capture_en = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winning request so later input changes cannot disturb the access
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_LDR;
      cur_id     <= REQ_CPU;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
    end else if (latch_en) begin
      last_grant <= pick_winner;
      cur_id     <= pick_winner;
      cur_we     <= (pick_winner == REQ_LDR) ? we1    : we0;
      cur_addr   <= (pick_winner == REQ_LDR) ? addr1  : addr0;
      cur_wdata  <= (pick_winner == REQ_LDR) ? wdata1 : wdata0;
    end
  end

  // Capture memory read data for the winner only; writes return the old contents
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (capture_en) begin
      if (cur_id == REQ_CPU) begin
        rdata0 <= mem_dataOut;
      end else begin
        rdata1 <= mem_dataOut;
      end
    end
  end

  // Address/data hold their last latched values outside SERVE; reset blocks a pending write
  assign mem_addr    = cur_addr;
  assign mem_dataIn  = cur_wdata;
  assign mem_regWrEn = (state == SERVE) && cur_we && !reset;
  assign ack0        = (state == DONE) && (cur_id == REQ_CPU) && !reset;
  assign ack1        = (state == DONE) && (cur_id == REQ_LDR) && !reset;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [9:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_regWrEn, busy;
  logic [31:0] rdata0, rdata1, mem_dataIn, mem_dataOut;
  logic [9:0]  mem_addr;

  logic [31:0] tb_mem [0:1023] = '{default: 32'h0};
  int          checks = 0;
  int          failures = 0;
  bit          both_ack_seen = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .we0         (we0),
    .addr0       (addr0),
    .wdata0      (wdata0),
    .ack0        (ack0),
    .rdata0      (rdata0),
    .req1        (req1),
    .we1         (we1),
    .addr1       (addr1),
    .wdata1      (wdata1),
    .ack1        (ack1),
    .rdata1      (rdata1),
    .mem_regWrEn (mem_regWrEn),
    .mem_addr    (mem_addr),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut),
    .busy        (busy)
  );

  // Single-port memory model: combinational read, write on the rising edge
  assign mem_dataOut = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_regWrEn) tb_mem[mem_addr] <= mem_dataIn;
  end

  // Watch for both acknowledges in the same cycle
  always @(negedge clk) begin
    if (ack0 && ack1) both_ack_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Tick until an acknowledge appears (bounded); reports who and how many ticks
  task automatic wait_any(output int who, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ack0 || ack1) && n < 12);
    who = ack1 ? 1 : (ack0 ? 0 : -1);
  endtask

  task automatic wait_ack(input string tag, input int exp_who, input int exp_lat);
    int who, n;
    wait_any(who, n);
    chk({tag, "_who"}, who, exp_who);
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  initial begin
    int who, n;
    int cnt0, cnt1;
    int exp_who;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_wren", mem_regWrEn, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_dataIn, 0);

    // Requester 1 writes DEADBEEF to address 5
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'd5; wdata1 = 32'hDEADBEEF;
    tick();
    chk("w1_busy", busy, 1);
    chk("w1_wren", mem_regWrEn, 1);
    chk("w1_addr", mem_addr, 5);
    chk("w1_din", mem_dataIn, 32'hDEADBEEF);
    chk("w1_ack_early", ack1, 0);
    tick();
    chk("w1_ack1", ack1, 1);
    chk("w1_ack0", ack0, 0);
    chk("w1_done_wren", mem_regWrEn, 0);
    chk("w1_rdata_old", rdata1, 0);
    req1 = 1'b0; we1 = 1'b0;
    tick();
    chk("w1_ack_pulse", ack1, 0);
    chk("w1_idle", busy, 0);
    chk("w1_mem", tb_mem[5], 32'hDEADBEEF);

    // Requester 0 reads it back
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd5;
    tick();
    chk("r0_wren", mem_regWrEn, 0);
    tick();
    chk("r0_ack0", ack0, 1);
    chk("r0_ack1", ack1, 0);
    chk("r0_rdata0", rdata0, 32'hDEADBEEF);
    chk("r0_rdata1_kept", rdata1, 0);
    req0 = 1'b0;
    tick();

    // Two writes from requester 0 leave last_grant at 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd7; wdata0 = 32'h11;
    wait_ack("w7", 0, 2);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd8; wdata0 = 32'h22;
    wait_ack("w8", 0, 2);
    req0 = 1'b0;
    tick();

    // Simultaneous reads: requester 1 first, then requester 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd7;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd8;
    wait_ack("cont_first", 1, 2);
    chk("cont_rdata1", rdata1, 32'h22);
    req1 = 1'b0;
    wait_ack("cont_second", 0, 3);
    chk("cont_rdata0", rdata0, 32'h11);
    chk("cont_rdata1_kept", rdata1, 32'h22);
    req0 = 1'b0;
    tick();

    // Continuous contention: six writes, grants alternate starting with 1
    cnt0 = 0; cnt1 = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd16; wdata0 = 32'hA0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'd32; wdata1 = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      exp_who = (i % 2 == 0) ? 1 : 0;
      wait_any(who, n);
      chk($sformatf("rr_grant%0d", i), who, exp_who);
      tick();
      if (who == 0) begin
        cnt0++;
        if (cnt0 == 3) req0 = 1'b0;
        else begin addr0 = 10'(16 + cnt0); wdata0 = 32'hA0 + cnt0; end
      end else if (who == 1) begin
        cnt1++;
        if (cnt1 == 3) req1 = 1'b0;
        else begin addr1 = 10'(32 + cnt1); wdata1 = 32'hB0 + cnt1; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rr_mem0_%0d", k), tb_mem[16 + k], 32'hA0 + k);
      chk($sformatf("rr_mem1_%0d", k), tb_mem[32 + k], 32'hB0 + k);
    end
    tick();

    // Reset during SERVE: no write, no acknowledge
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd9; wdata0 = 32'h55;
    tick();
    chk("ra_wren_pre", mem_regWrEn, 1);
    reset = 1'b1;
    req0 = 1'b0;
    #1;
    chk("ra_wren_forced", mem_regWrEn, 0);
    tick();
    chk("ra_busy", busy, 0);
    chk("ra_ack0", ack0, 0);
    chk("ra_mem9", tb_mem[9], 0);
    reset = 1'b0;
    tick();
    chk("ra_ack0_late", ack0, 0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd9;
    wait_ack("ra_read", 0, 2);
    chk("ra_rdata0", rdata0, 0);
    req0 = 1'b0;
    tick();

    // Idle: nothing happens for ten cycles
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("idle_busy%0d", c), busy, 0);
      chk($sformatf("idle_wren%0d", c), mem_regWrEn, 0);
      chk($sformatf("idle_acks%0d", c), {ack0, ack1}, 2'b00);
    end

    chk("never_both_acks", both_ack_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
